// File: rtl/bram_arb_pkg.sv
// Shared definitions for the single-port BRAM arbiter.
//   rw_e : access direction carried with each request (RW_READ = 0, RW_WRITE = 1).
package bram_arb_pkg;

   typedef enum logic {
      RW_READ  = 1'b0,
      RW_WRITE = 1'b1
   } rw_e;

endpackage : bram_arb_pkg

// File: rtl/bram_sp.sv
// Single-port block RAM with a registered read port.
//   clk   : clock, all activity on posedge
//   en    : access enable for this cycle
//   rw    : RW_WRITE stores din at addr, RW_READ loads mem[addr] into dout
//   addr  : word address
//   din   : write data
//   dout  : read data; holds the last word read until the next read
module bram_sp
   import bram_arb_pkg::*;
#(
   parameter  int WIDTH = 36,
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  rw_e              rw,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] dout_q, dout_d;

   // NOTE: storage arrays are never reset; a reset would stop the tools mapping this onto a block RAM.
   always_ff @(posedge clk) begin
      if (en && (rw == RW_WRITE)) begin
         mem[addr] <= din;
      end
   end

   // Output register only changes on a read, so writes and idle cycles leave it alone.
   always_comb begin
      // NOTE: default first so every path assigns dout_d and no latch is inferred.
      dout_d = dout_q;
      if (en && (rw == RW_READ)) begin
         dout_d = mem[addr];
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk) begin
      dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule : bram_sp

// File: rtl/bram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters.
// At most one access per cycle; reads return one cycle after acceptance.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester request pending
//   req_ready  : per-requester accept this cycle (one-hot or zero)
//   req_rw     : per-requester direction, 1 = write, 0 = read
//   req_addr   : packed addresses, requester i at [i*AW +: AW]
//   req_wdata  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  : per-requester read-data-valid pulse (one-hot or zero)
//   rsp_data   : shared read data bus
module bram_sp_arbiter
   import bram_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int WIDTH   = 36,
   parameter  int DEPTH   = 1024,
   localparam int AW      = $clog2(DEPTH),
   localparam int PW      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_rw,
   input  logic [NUM_REQ*AW-1:0]    req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]         rsp_data
);

   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   rsp_pending_q, rsp_pending_d;

   logic [2*NUM_REQ-1:0] valid_dbl, pick_dbl;
   logic [NUM_REQ-1:0]   valid_rot, pick_rot, grant;
   logic [PW-1:0]        grant_idx;
   logic                 grant_any;
   rw_e                  sel_rw;
   logic [AW-1:0]        sel_addr;
   logic [WIDTH-1:0]     sel_wdata;

   // Rotate so the pointer's requester sits at bit 0, keep the lowest set
   // bit, then rotate back. Doubling the vector turns the shifts into rotates.
   always_comb begin
      valid_dbl = {req_valid, req_valid} >> ptr_q;
      valid_rot = valid_dbl[NUM_REQ-1:0];
      pick_rot  = valid_rot & (~valid_rot + NUM_REQ'(1));
      pick_dbl  = {pick_rot, pick_rot} << ptr_q;
      grant     = rst ? '0 : pick_dbl[2*NUM_REQ-1:NUM_REQ];
   end

   // Route the granted requester's command to the BRAM.
   always_comb begin
      grant_idx = '0;
      sel_rw    = RW_READ;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PW'(i);
            sel_rw    = rw_e'(req_rw[i]);
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign grant_any = |grant;

   always_comb begin
      ptr_d = ptr_q;
      if (grant_any) begin
         ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end
      // Remember which requester owns the read completing next cycle.
      rsp_pending_d = (sel_rw == RW_READ) ? grant : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q         <= '0;
         rsp_pending_q <= '0;
      end else begin
         ptr_q         <= ptr_d;
         rsp_pending_q <= rsp_pending_d;
      end
   end

   assign req_ready = grant;
   // A response due during reset is dropped rather than pulsed.
   assign rsp_valid = rsp_pending_q & ~{NUM_REQ{rst}};

   bram_sp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_bram (
      .clk  (clk),
      .en   (grant_any),
      .rw   (sel_rw),
      .addr (sel_addr),
      .din  (sel_wdata),
      .dout (rsp_data)
   );

endmodule : bram_sp_arbiter

// File: tb/tb_bram_sp_arbiter.sv
module tb_bram_sp_arbiter;

   localparam int N  = 2;
   localparam int W  = 36;
   localparam int D  = 1024;
   localparam int AW = $clog2(D);

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid, req_ready, req_rw, rsp_valid;
   logic [N*AW-1:0]  req_addr;
   logic [N*W-1:0]   req_wdata;
   logic [W-1:0]     rsp_data;

   bram_sp_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         id;
      logic [W-1:0] data;
      bit         known;
      int         due;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_mem   [D];
   bit           m_known [D];
   int           m_ptr    = 0;
   int           m_last_g = -1;

   // Requester-side stimulus state
   bit           cur_v  [N];
   bit           cur_rw [N];
   logic [AW-1:0] cur_addr [N];
   logic [W-1:0] cur_wd [N];

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = cur_v[i];
         req_rw[i]              = cur_rw[i];
         req_addr[i*AW +: AW]   = cur_addr[i];
         req_wdata[i*W +: W]    = cur_wd[i];
      end
   endtask

   // One clock cycle: drive, compare grant against the model at the
   // negative edge, update the model, then move to just after the next edge.
   // exp_gnt: -2 no directed check, -1 expect no grant, else expected requester.
   task automatic step(input logic r, input int exp_gnt);
      int g;
      rst = r;
      drive_inputs();
      @(negedge clk);
      g = -1;
      if (!r) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && cur_v[idx]) g = idx;
         end
      end
      check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      if (exp_gnt == -1) check("dir_no_grant", req_ready, 64'd0);
      else if (exp_gnt >= 0) check("dir_grant", req_ready, 64'd1 << exp_gnt);
      m_last_g = g;
      if (r) begin
         m_ptr = 0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         if (cur_rw[g]) begin
            m_mem[cur_addr[g]]   = cur_wd[g];
            m_known[cur_addr[g]] = 1'b1;
         end else begin
            exp_t e;
            e.id    = g;
            e.data  = m_mem[cur_addr[g]];
            e.known = m_known[cur_addr[g]];
            e.due   = cyc + 1;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("rsp_in_reset", rsp_valid, 64'd0);
         sb.delete();
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         check("rsp_valid", rsp_valid, 64'd1 << e.id);
         if (e.known) check("rsp_data", rsp_data, e.data);
      end else begin
         check("rsp_idle", rsp_valid, 64'd0);
      end
   end

   task automatic set_req(input int i, input bit v, input bit rw, input int addr, input logic [W-1:0] wd);
      cur_v[i]    = v;
      cur_rw[i]   = rw;
      cur_addr[i] = AW'(addr);
      cur_wd[i]   = wd;
   endtask

   task automatic all_idle();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
      for (int a = 0; a < D; a++) m_known[a] = 1'b0;
      rst = 1'b1;
      all_idle();
      drive_inputs();
      @(posedge clk);
      #1;

      // Reset held with every requester valid: no grants, then 0 first, then alternation.
      set_req(0, 1'b1, 1'b0, 1, '0);
      set_req(1, 1'b1, 1'b0, 2, '0);
      step(1'b1, -1);
      step(1'b1, -1);
      for (int k = 0; k < 6; k++) step(1'b0, exp_seq[k]);
      all_idle();
      step(1'b0, -1);

      // Write then read-back by the other requester on the next cycle.
      set_req(0, 1'b1, 1'b1, 5, 36'h0ABCD);
      step(1'b0, 0);
      all_idle();
      set_req(1, 1'b1, 1'b0, 5, '0);
      step(1'b0, 1);
      check("t3_rsp_valid", rsp_valid, 64'b10);
      check("t3_rsp_data", rsp_data, 36'h0ABCD);
      all_idle();
      step(1'b0, -1);

      // Preload 0..3 with 10..13, then back-to-back reads from requester 0.
      for (int a = 0; a < 4; a++) begin
         set_req(0, 1'b1, 1'b1, a, W'(10 + a));
         step(1'b0, 0);
      end
      for (int a = 0; a < 4; a++) begin
         set_req(0, 1'b1, 1'b0, a, '0);
         step(1'b0, 0);
         check("t4_rsp_valid", rsp_valid, 64'b01);
         check("t4_rsp_data", rsp_data, 64'(10 + a));
      end
      all_idle();
      step(1'b0, -1);

      // Stall: pointer brought to 0, req0 wins, req1 holds and goes next.
      set_req(1, 1'b1, 1'b0, 5, '0);
      step(1'b0, 1);
      set_req(0, 1'b1, 1'b0, 2, '0);
      set_req(1, 1'b1, 1'b0, 3, '0);
      step(1'b0, 0);
      set_req(0, 1'b0, 1'b0, 0, '0);
      step(1'b0, 1);
      check("t5_rsp_valid", rsp_valid, 64'b10);
      check("t5_rsp_data", rsp_data, 64'd13);
      set_req(0, 1'b1, 1'b0, 0, '0);
      set_req(1, 1'b1, 1'b0, 1, '0);
      step(1'b0, 0);
      all_idle();
      step(1'b0, -1);

      // Reset the cycle after a read is accepted: no response, pointer back to 0.
      set_req(0, 1'b1, 1'b0, 1, '0);
      step(1'b0, 0);
      all_idle();
      rst = 1'b1;
      drive_inputs();
      #1;
      check("t6_no_pulse", rsp_valid, 64'd0);
      step(1'b1, -1);
      step(1'b0, -1);
      check("t6_after_rst", rsp_valid, 64'd0);
      set_req(0, 1'b1, 1'b0, 2, '0);
      set_req(1, 1'b1, 1'b0, 3, '0);
      step(1'b0, 0);
      all_idle();
      step(1'b0, -1);

      // Random traffic honouring the hold-while-stalled rule.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!cur_v[i] || m_last_g == i) begin
               set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 15), W'({$urandom, $urandom}));
            end else if ($urandom_range(0, 7) == 0) begin
               cur_v[i] = 1'b0;
            end
         end
         step($urandom_range(0, 59) == 0, -2);
      end

      all_idle();
      step(1'b0, -2);
      step(1'b0, -2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_bram_sp_arbiter
